// File: rtl/multi_pulse_gen_pkg.sv
// multi_pulse_gen shared package: edge-mode encodings and default sizing.
// Optional build macro: MULTI_PULSE_GEN_SYNC_EN (input synchronisers).
package multi_pulse_gen_pkg;

  localparam logic [1:0] MODE_RISE = 2'b00;
  localparam logic [1:0] MODE_FALL = 2'b01;
  localparam logic [1:0] MODE_BOTH = 2'b10;
  localparam logic [1:0] MODE_OFF  = 2'b11;

  localparam int DEF_CNT_W = 4;

endpackage

// File: rtl/multi_pulse_gen_ch.sv
// pulse_gen_ch: one channel of edge detect plus stretched output pulse.
// MULTI_PULSE_GEN_SYNC_EN adds a 2-flop synchroniser ahead of detection.
module pulse_gen_ch
  import multi_pulse_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             lvl_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] pw_i,
  input  logic             retrig_i,
  output logic             pulse_o,
  output logic             miss_o
);

  logic             src;
  logic             prev_q, prev_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             miss_q, miss_d;
  logic             rise, fall, edge_det;
  logic [CNT_W-1:0] reload;

`ifdef MULTI_PULSE_GEN_SYNC_EN
  logic [1:0] sync_q;

  // Two-stage synchroniser for an asynchronous level input
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[0], lvl_i};
  end

  assign src = sync_q[1];
`else
  assign src = lvl_i;
`endif

  assign rise   = src & ~prev_q;
  assign fall   = ~src & prev_q;
  assign reload = (pw_i == '0) ? '0 : pw_i - CNT_W'(1);

  // Polarity select; nothing is detected until armed
  always_comb begin
    edge_det = 1'b0;
    unique case (mode_i)
      MODE_RISE: edge_det = rise;
      MODE_FALL: edge_det = fall;
      MODE_BOTH: edge_det = rise | fall;
      MODE_OFF:  edge_det = 1'b0;
      default:   edge_det = 1'b0;
    endcase
    edge_det = edge_det & armed_q;
  end

  // Next-state: reload, countdown, abort or miss flag
  always_comb begin
    prev_d  = src;
    armed_d = 1'b1;
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    miss_d  = 1'b0;
    if (mode_i == MODE_OFF) begin
      cnt_d   = '0;
      pulse_d = 1'b0;
    end else if (edge_det && (!pulse_q || retrig_i)) begin
      cnt_d   = reload;
      pulse_d = 1'b1;
    end else begin
      miss_d = edge_det;
      if (pulse_q) begin
        if (cnt_q != '0) cnt_d   = cnt_q - CNT_W'(1);
        else             pulse_d = 1'b0;
      end
    end
  end

  // Channel state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      miss_q  <= miss_d;
    end
  end

  assign pulse_o = pulse_q;
  assign miss_o  = miss_q;

endmodule

// File: rtl/multi_pulse_gen.sv
// multi_pulse_gen: NUM_CH independent edge-to-pulse channels.
// Build macro MULTI_PULSE_GEN_SYNC_EN enables per-channel input synchronisers.
module multi_pulse_gen
  import multi_pulse_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NUM_CH-1:0]       LVL_IN,
  input  logic [2*NUM_CH-1:0]     MODE,
  input  logic [CNT_W*NUM_CH-1:0] PULSE_W,
  input  logic [NUM_CH-1:0]       RETRIG,
  output logic [NUM_CH-1:0]       PULSE_OUT,
  output logic [NUM_CH-1:0]       BUSY,
  output logic [NUM_CH-1:0]       EDGE_MISS
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pulse_gen_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_i   (CLK),
      .rst_ni  (RST),
      .lvl_i   (LVL_IN[i]),
      .mode_i  (MODE[2*i +: 2]),
      .pw_i    (PULSE_W[CNT_W*i +: CNT_W]),
      .retrig_i(RETRIG[i]),
      .pulse_o (PULSE_OUT[i]),
      .miss_o  (EDGE_MISS[i])
    );
  end

  assign BUSY = PULSE_OUT;

endmodule

// File: tb/tb_multi_pulse_gen.sv
// tb_multi_pulse_gen: directed scoreboard bench for multi_pulse_gen.
// Expected latency follows MULTI_PULSE_GEN_SYNC_EN when defined.
module tb_multi_pulse_gen;

`ifdef MULTI_PULSE_GEN_SYNC_EN
  localparam int         LAT     = 2;
  localparam logic [3:0] RST_LVL = 4'b0000;
`else
  localparam int         LAT     = 0;
  localparam logic [3:0] RST_LVL = 4'b1111;
`endif

  logic        clk;
  logic        rst_n;
  logic [3:0]  lvl;
  logic [7:0]  mode;
  logic [15:0] pw;
  logic [3:0]  retrig;
  logic [3:0]  pulse;
  logic [3:0]  busy;
  logic [3:0]  miss;

  typedef struct packed {
    logic [3:0] p;
    logic [3:0] m;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  multi_pulse_gen #(
    .NUM_CH(4),
    .CNT_W (4)
  ) dut (
    .CLK      (clk),
    .RST      (rst_n),
    .LVL_IN   (lvl),
    .MODE     (mode),
    .PULSE_W  (pw),
    .RETRIG   (retrig),
    .PULSE_OUT(pulse),
    .BUSY     (busy),
    .EDGE_MISS(miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end else begin
      e = q.pop_front();
      chk({tag, ".pulse"}, pulse, e.p);
      chk({tag, ".busy"},  busy,  e.p);
      chk({tag, ".miss"},  miss,  e.m);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] ep,
                      input logic [3:0] em);
    exp_t e;
    e.p = ep;
    e.m = em;
    q.push_back(e);
    @(posedge clk);
    #1;
    pop_cmp(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 4'b0000, 4'b0000);
  endtask

  initial begin
    exp_t e;
    rst_n  = 1'b0;
    lvl    = RST_LVL;
    mode   = 8'h00;
    pw     = 16'h0000;
    retrig = 4'b0000;
    #3;
    e = '0;
    q.push_back(e);
    pop_cmp("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle("rst_rel", 10);

    lvl = 4'b0000;
    idle("lvl_low", LAT + 2);
    mode = 8'b00_10_01_00;
    idle("mode_set", 2);

    lvl[0] = 1'b1;
    idle("ch0_lat", LAT);
    step("ch0_w1", 4'b0001, 4'b0000);
    idle("ch0_end", 2);

    pw[7:4] = 4'd5;
    lvl[1]  = 1'b1;
    idle("ch1_rise", LAT + 3);
    lvl[1] = 1'b0;
    idle("ch1_lat", LAT);
    repeat (5) step("ch1_w5", 4'b0010, 4'b0000);
    idle("ch1_end", 2);

    pw[11:8]  = 4'd4;
    retrig[2] = 1'b1;
    lvl[2]    = 1'b1;
    idle("ch2r_lat", LAT);
    repeat (2) step("ch2r_a", 4'b0100, 4'b0000);
    lvl[2] = 1'b0;
    repeat (4) step("ch2r_b", 4'b0100, 4'b0000);
    idle("ch2r_end", 2);

    retrig[2] = 1'b0;
    lvl[2]    = 1'b1;
    idle("ch2n_lat", LAT);
    repeat (2) step("ch2n_a", 4'b0100, 4'b0000);
    lvl[2] = 1'b0;
    step("ch2n_miss", 4'b0100, 4'b0100);
    step("ch2n_c", 4'b0100, 4'b0000);
    idle("ch2n_end", LAT + 2);

    pw[15:12] = 4'd8;
    lvl[3]    = 1'b1;
    idle("ch3_lat", LAT);
    repeat (3) step("ch3_run", 4'b1000, 4'b0000);
    mode[7:6] = 2'b11;
    idle("ch3_abort", 3);
    mode[7:6] = 2'b00;
    idle("ch3_reen", LAT + 3);

    mode   = 8'h00;
    pw     = 16'h8888;
    retrig = 4'b0000;
    lvl    = 4'b0000;
    idle("all_low", LAT + 2);
    lvl = 4'b1111;
    idle("all_lat", LAT);
    repeat (2) step("all_run", 4'b1111, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    e = '0;
    q.push_back(e);
    pop_cmp("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle("rearm_hi", 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
